hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 191 +++++++++++++++++++
 tb/tb_hazard_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard controller for a five-stage pipeline: operand forwarding, load-use
// stalls, branch flushes, data-memory wait stalls with a sticky timeout, and
// saturating stall/flush performance counters.
module hazard_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ra1_d,
  input  logic [3:0]  ra2_d,
  input  logic [3:0]  ra1_e,
  input  logic [3:0]  ra2_e,
  input  logic [3:0]  wa_e,
  input  logic [3:0]  wa_m,
  input  logic [3:0]  wa_w,
  input  logic        reg_write_m,
  input  logic        reg_write_w,
  input  logic        mem_reg_e,
  input  logic        branch_taken_e,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        timeout_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LDSTALL  = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  // Pipeline-register control bundle produced by the FSM each cycle.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
  } ctrl_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [3:0] REG_PC  = 4'b1111;  // r15 never forwards
  localparam logic [31:0] TO_LIM = TIMEOUT;

  state_e      state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  ctrl_t       ctrl;

  logic        mem_miss;
  logic        load_use;

  // Memory stage wins over write-back so the youngest producer is used.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       rw_m,
    input logic [3:0] wm,
    input logic       rw_w,
    input logic [3:0] ww
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ra != REG_PC) begin
      if (rw_m && (wm == ra))      sel = FWD_MEM;
      else if (rw_w && (ww == ra)) sel = FWD_WB;
    end
    return sel;
  endfunction

  // Forwarding selects, forced to register file while in reset.
  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    if (!rst) begin
      forward_a_e = fwd_sel(ra1_e, reg_write_m, wa_m, reg_write_w, wa_w);
      forward_b_e = fwd_sel(ra2_e, reg_write_m, wa_m, reg_write_w, wa_w);
    end
  end

  assign mem_miss = mem_req_m & ~mem_ready;
  assign load_use = mem_reg_e & ((wa_e == ra1_d) | (wa_e == ra2_d));

  // Next-state and control outputs; events are only taken in RUN.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ctrl    = '0;
    unique case (state_q)
      RUN: begin
        if (mem_miss) begin
          ctrl.stall_f = 1'b1;
          ctrl.stall_d = 1'b1;
          ctrl.stall_e = 1'b1;
          ctrl.stall_m = 1'b1;
          wait_d       = '0;
          state_d      = MEM_WAIT;
        end else if (branch_taken_e) begin
          // A coincident load-use is dropped: the flush kills the consumer.
          ctrl.flush_d = 1'b1;
          ctrl.flush_e = 1'b1;
          state_d      = FLUSH;
        end else if (load_use) begin
          ctrl.stall_f = 1'b1;
          ctrl.stall_d = 1'b1;
          ctrl.flush_e = 1'b1;
          state_d      = LDSTALL;
        end
      end
      LDSTALL: begin
        // Bubble moves forward with every control line idle.
        state_d = RUN;
      end
      FLUSH: begin
        ctrl.flush_d = 1'b1;
        state_d      = RUN;
      end
      MEM_WAIT: begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.stall_e = 1'b1;
        ctrl.stall_m = 1'b1;
        wait_d       = wait_q + 32'd1;
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_q == TO_LIM) begin
          err_d   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      ctrl    = '0;
      state_d = RUN;
      wait_d  = '0;
      err_d   = 1'b0;
    end
  end

  // Saturating performance counters driven by the gated control lines.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ctrl.stall_f && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (ctrl.flush_e && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // State, wait counter, sticky error and counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_f     = ctrl.stall_f;
  assign stall_d     = ctrl.stall_d;
  assign stall_e     = ctrl.stall_e;
  assign stall_m     = ctrl.stall_m;
  assign flush_d     = ctrl.flush_d;
  assign flush_e     = ctrl.flush_e;
  assign timeout_err = err_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with TIMEOUT=8.
module tb_hazard_controller;
  logic        clk;
  logic        rst;
  logic [3:0]  ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w;
  logic        reg_write_m, reg_write_w, mem_reg_e, branch_taken_e;
  logic        mem_req_m, mem_ready;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic        timeout_err;
  logic [15:0] stall_cnt, flush_cnt;

  int n_chk;
  int n_pass;

  hazard_controller #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e),
    .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_reg_e(mem_reg_e), .branch_taken_e(branch_taken_e),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
  logic [5:0] ctl;
  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ra1_d = 4'd0; ra2_d = 4'd0; ra1_e = 4'd0; ra2_e = 4'd0;
    wa_e = 4'd9; wa_m = 4'd0; wa_w = 4'd0;
    reg_write_m = 1'b0; reg_write_w = 1'b0;
    mem_reg_e = 1'b0; branch_taken_e = 1'b0;
    mem_req_m = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    // Busy inputs while in reset must not leak to the outputs.
    mem_req_m = 1'b1; branch_taken_e = 1'b1; mem_reg_e = 1'b1; wa_e = 4'd0;
    reg_write_m = 1'b1; wa_m = 4'd0;
    cyc(); cyc();
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL reset_ctl got %b exp %b", ctl, 6'b0); else n_pass++;
    n_chk++; if ({forward_a_e, forward_b_e} !== 4'b0) $display("FAIL reset_fwd got %b exp 0000", {forward_a_e, forward_b_e}); else n_pass++;
    idle_inputs();
    rst = 1'b0;
    #2;
    n_chk++; if ({timeout_err, stall_cnt, flush_cnt} !== 33'd0) $display("FAIL reset_regs got err=%0d sc=%0d fc=%0d exp 0", timeout_err, stall_cnt, flush_cnt); else n_pass++;
    n_chk++; if (ctl !== 6'b0) $display("FAIL reset_idle got %b exp %b", ctl, 6'b0); else n_pass++;
  endtask

  typedef struct {
    logic       rwm; logic [3:0] wam;
    logic       rww; logic [3:0] waw;
    logic [3:0] ra1; logic [3:0] ra2;
    logic [1:0] ea;  logic [1:0] eb;
  } fwd_vec_t;

  task automatic test_forwarding();
    fwd_vec_t v[7];
    v[0] = '{1'b1, 4'd5,  1'b1, 4'd5,  4'd5,  4'd0, 2'b10, 2'b00};
    v[1] = '{1'b1, 4'd5,  1'b1, 4'd5,  4'd15, 4'd0, 2'b00, 2'b00};
    v[2] = '{1'b1, 4'd15, 1'b1, 4'd15, 4'd15, 4'd15, 2'b00, 2'b00};
    v[3] = '{1'b0, 4'd5,  1'b1, 4'd5,  4'd5,  4'd5, 2'b01, 2'b01};
    v[4] = '{1'b1, 4'd3,  1'b1, 4'd7,  4'd3,  4'd7, 2'b10, 2'b01};
    v[5] = '{1'b1, 4'd4,  1'b0, 4'd4,  4'd4,  4'd4, 2'b10, 2'b10};
    v[6] = '{1'b0, 4'd2,  1'b0, 4'd2,  4'd2,  4'd2, 2'b00, 2'b00};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      reg_write_m = v[i].rwm; wa_m = v[i].wam;
      reg_write_w = v[i].rww; wa_w = v[i].waw;
      ra1_e = v[i].ra1; ra2_e = v[i].ra2;
      #2;
      n_chk++; if (forward_a_e !== v[i].ea) $display("FAIL fwd_a[%0d] got %b exp %b", i, forward_a_e, v[i].ea); else n_pass++;
      n_chk++; if (forward_b_e !== v[i].eb) $display("FAIL fwd_b[%0d] got %b exp %b", i, forward_b_e, v[i].eb); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    mem_reg_e = 1'b1; wa_e = 4'd3; ra1_d = 4'd3;
    #2;
    n_chk++; if (ctl !== 6'b110001) $display("FAIL lu_first got %b exp %b", ctl, 6'b110001); else n_pass++;
    cyc();
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL lu_ldstall got %b exp %b", ctl, 6'b0); else n_pass++;
    idle_inputs();
    cyc();
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL lu_after got %b exp %b", ctl, 6'b0); else n_pass++;
    n_chk++; if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); else n_pass++;
    n_chk++; if (flush_cnt !== 16'd1) $display("FAIL lu_flush_cnt got %0d exp 1", flush_cnt); else n_pass++;
    // Hazard through the second source.
    mem_reg_e = 1'b1; wa_e = 4'd6; ra1_d = 4'd1; ra2_d = 4'd6;
    #2;
    n_chk++; if (ctl !== 6'b110001) $display("FAIL lu_ra2 got %b exp %b", ctl, 6'b110001); else n_pass++;
    cyc();
    // Same registers but not a load: no hazard.
    mem_reg_e = 1'b0;
    cyc();
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL lu_noload got %b exp %b", ctl, 6'b0); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken_e = 1'b1;
    #2;
    n_chk++; if (ctl !== 6'b000011) $display("FAIL br_first got %b exp %b", ctl, 6'b000011); else n_pass++;
    cyc();
    branch_taken_e = 1'b0;
    #2;
    n_chk++; if (ctl !== 6'b000010) $display("FAIL br_flushst got %b exp %b", ctl, 6'b000010); else n_pass++;
    cyc();
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL br_after got %b exp %b", ctl, 6'b0); else n_pass++;
    n_chk++; if (flush_cnt !== 16'd1) $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); else n_pass++;
    // Branch with a coincident load-use: only the flush happens.
    branch_taken_e = 1'b1; mem_reg_e = 1'b1; wa_e = 4'd3; ra1_d = 4'd3;
    #2;
    n_chk++; if (ctl !== 6'b000011) $display("FAIL br_lu got %b exp %b", ctl, 6'b000011); else n_pass++;
    cyc();
    idle_inputs();
    cyc();
    #2;
    n_chk++; if (stall_cnt !== 16'd0) $display("FAIL br_stall_cnt got %0d exp 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_chk++; if (ctl !== 6'b111100) $display("FAIL mw_stall[%0d] got %b exp %b", i, ctl, 6'b111100); else n_pass++;
      cyc();
    end
    mem_ready = 1'b1;
    #2;
    n_chk++; if (ctl !== 6'b111100) $display("FAIL mw_ready got %b exp %b", ctl, 6'b111100); else n_pass++;
    cyc();
    idle_inputs();
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL mw_run got %b exp %b", ctl, 6'b0); else n_pass++;
    n_chk++; if (stall_cnt !== 16'd5) $display("FAIL mw_stall_cnt got %0d exp 5", stall_cnt); else n_pass++;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL mw_err got %b exp 0", timeout_err); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0;
    repeat (9) cyc();
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL to_early got %b exp 0", timeout_err); else n_pass++;
    cyc();
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL to_set got %b exp 1", timeout_err); else n_pass++;
    idle_inputs();
    repeat (3) cyc();
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL to_sticky got %b exp 1", timeout_err); else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL to_clear got %b exp 0", timeout_err); else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0; branch_taken_e = 1'b1;
    #2;
    n_chk++; if (ctl !== 6'b111100) $display("FAIL col_first got %b exp %b", ctl, 6'b111100); else n_pass++;
    cyc();
    branch_taken_e = 1'b0; mem_ready = 1'b1;
    #2;
    n_chk++; if (ctl !== 6'b111100) $display("FAIL col_wait got %b exp %b", ctl, 6'b111100); else n_pass++;
    cyc();
    idle_inputs();
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL col_run got %b exp %b", ctl, 6'b0); else n_pass++;
    n_chk++; if (flush_cnt !== 16'd0) $display("FAIL col_flush_cnt got %0d exp 0", flush_cnt); else n_pass++;
    n_chk++; if (stall_cnt !== 16'd2) $display("FAIL col_stall_cnt got %0d exp 2", stall_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL rm_wait_inrst got %b exp %b", ctl, 6'b0); else n_pass++;
    idle_inputs();
    cyc();
    rst = 1'b0;
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL rm_wait_after got %b exp %b", ctl, 6'b0); else n_pass++;
    branch_taken_e = 1'b1;
    cyc();
    branch_taken_e = 1'b0;
    rst = 1'b1;
    #2;
    n_chk++; if (flush_d !== 1'b0) $display("FAIL rm_flush_inrst got %b exp 0", flush_d); else n_pass++;
    cyc();
    rst = 1'b0;
    #2;
    n_chk++; if (ctl !== 6'b0) $display("FAIL rm_flush_after got %b exp %b", ctl, 6'b0); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req_m = 1'b1; mem_ready = 1'b0;
    // Memory misses with timeouts keep stall_f high every cycle.
    repeat (65540) cyc();
    n_chk++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_reach got %h exp ffff", stall_cnt); else n_pass++;
    repeat (20) cyc();
    n_chk++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h exp ffff", stall_cnt); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
